// File: rtl/id_ex_ctrl.sv
// ID/EX control register: decodes the ID-stage opcode, detects load-use hazards and inserts bubbles.
// Optional load-use stall counter is built when STALL_CNT_EN is defined.
module id_ex_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        flush_i,
    output logic        valid_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        mem_read_e,
    output logic        alu_src_e,
    output logic        result_src_e,
    output logic        branch_e,
    output logic [1:0]  imm_src_e,
    output logic [4:0]  rd_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic        illegal_e,
    output logic        stall_f,
    output logic        stall_d
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       supported;
    logic       uses_rs2;
    logic       dec_reg_write, dec_mem_write, dec_mem_read;
    logic       dec_alu_src, dec_result_src, dec_branch;
    logic [1:0] dec_imm_src;
    logic       hazard;
    logic       bubble;
    logic       illegal_next;

    assign rs1_d = instr_d[19:15];
    assign rs2_d = instr_d[24:20];
    assign rd_d  = instr_d[11:7];

    always_comb begin
        supported      = 1'b1;
        uses_rs2       = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_alu_src    = 1'b0;
        dec_result_src = 1'b0;
        dec_branch     = 1'b0;
        dec_imm_src    = 2'b00;
        case (instr_d[6:0])
            OP_IALU: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 1'b1;
            end
            OP_STORE: begin
                dec_imm_src   = 2'b01;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm_src = 2'b10;
                dec_branch  = 1'b1;
                uses_rs2    = 1'b1;
            end
            default: supported = 1'b0;
        endcase
    end

    // rs1 is a source of every supported format; an unsupported opcode has no sources
    assign hazard = valid_d && mem_read_e && valid_e && (rd_e != 5'd0) && supported &&
                    ((rd_e == rs1_d) || (uses_rs2 && (rd_e == rs2_d)));

    assign stall_f      = hazard && !flush_i;
    assign stall_d      = hazard && !flush_i;
    assign bubble       = hazard || flush_i || !valid_d || !supported;
    assign illegal_next = valid_d && !flush_i && !supported;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e      <= 1'b0;
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            mem_read_e   <= 1'b0;
            alu_src_e    <= 1'b0;
            result_src_e <= 1'b0;
            branch_e     <= 1'b0;
            imm_src_e    <= 2'b00;
            rd_e         <= 5'd0;
            rs1_e        <= 5'd0;
            rs2_e        <= 5'd0;
            illegal_e    <= 1'b0;
        end else begin
            illegal_e <= illegal_next;
            if (bubble) begin
                valid_e      <= 1'b0;
                reg_write_e  <= 1'b0;
                mem_write_e  <= 1'b0;
                mem_read_e   <= 1'b0;
                alu_src_e    <= 1'b0;
                result_src_e <= 1'b0;
                branch_e     <= 1'b0;
                imm_src_e    <= 2'b00;
                rd_e         <= 5'd0;
                rs1_e        <= 5'd0;
                rs2_e        <= 5'd0;
            end else begin
                valid_e      <= 1'b1;
                reg_write_e  <= dec_reg_write;
                mem_write_e  <= dec_mem_write;
                mem_read_e   <= dec_mem_read;
                alu_src_e    <= dec_alu_src;
                result_src_e <= dec_result_src;
                branch_e     <= dec_branch;
                imm_src_e    <= dec_imm_src;
                rd_e         <= rd_d;
                rs1_e        <= rs1_d;
                rs2_e        <= rs2_d;
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (stall_d) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Directed scoreboard bench for id_ex_ctrl: expected EX-stage state is queued when an
// instruction is driven and compared one edge later.
module tb_id_ex_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        flush_i;
    logic        valid_e, reg_write_e, mem_write_e, mem_read_e;
    logic        alu_src_e, result_src_e, branch_e;
    logic [1:0]  imm_src_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;
    logic        illegal_e, stall_f, stall_d;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_assert;
    int n_fail;
    int exp_cnt;

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       as;
        logic       rs;
        logic       br;
        logic [1:0] imm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ill;
    } ex_t;

    ex_t sb_q[$];

    id_ex_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_d      (instr_d),
        .valid_d      (valid_d),
        .flush_i      (flush_i),
        .valid_e      (valid_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .mem_read_e   (mem_read_e),
        .alu_src_e    (alu_src_e),
        .result_src_e (result_src_e),
        .branch_e     (branch_e),
        .imm_src_e    (imm_src_e),
        .rd_e         (rd_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .illegal_e    (illegal_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [6:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], op};
    endfunction

    // Expected EX contents, built from the opcode table
    function automatic ex_t model(input logic [31:0] ins, input logic enters, input logic ill);
        ex_t e;
        e = '0;
        e.ill = ill;
        if (enters) begin
            e.valid = 1'b1;
            e.rd    = ins[11:7];
            e.rs1   = ins[19:15];
            e.rs2   = ins[24:20];
            case (ins[6:0])
                7'b0010011: begin e.rw = 1; e.as = 1; end
                7'b0000011: begin e.rw = 1; e.mr = 1; e.as = 1; e.rs = 1; end
                7'b0100011: begin e.imm = 2'b01; e.mw = 1; e.as = 1; end
                7'b0110011: begin e.rw = 1; end
                7'b1100011: begin e.imm = 2'b10; e.br = 1; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input ex_t e);
        chk({tag, ".valid_e"}, {31'd0, valid_e}, {31'd0, e.valid});
        chk({tag, ".ctrl"},
            {25'd0, reg_write_e, mem_write_e, mem_read_e, alu_src_e, result_src_e, branch_e, illegal_e},
            {25'd0, e.rw, e.mw, e.mr, e.as, e.rs, e.br, e.ill});
        chk({tag, ".imm_src_e"}, {30'd0, imm_src_e}, {30'd0, e.imm});
        chk({tag, ".idx"}, {17'd0, rd_e, rs1_e, rs2_e}, {17'd0, e.rd, e.rs1, e.rs2});
    endtask

    task automatic chk_cnt(input string tag);
`ifdef STALL_CNT_EN
        chk({tag, ".stall_cnt"}, stall_cnt, exp_cnt);
`endif
    endtask

    // Starts just after a rising edge; checks stall combinationally, then EX one edge later
    task automatic step(input string tag, input logic [31:0] ins, input logic v, input logic fl,
                        input logic es, input logic enters, input logic ill);
        ex_t e;
        instr_d = ins;
        valid_d = v;
        flush_i = fl;
        #1;
        chk({tag, ".stall_f"}, {31'd0, stall_f}, {31'd0, es});
        chk({tag, ".stall_d"}, {31'd0, stall_d}, {31'd0, es});
        sb_q.push_back(model(ins, enters, ill));
        @(posedge clk);
        #1;
        if (es) exp_cnt++;
        e = sb_q.pop_front();
        chk_ex(tag, e);
        chk_cnt(tag);
        $display("step %-10s instr=%h valid_d=%0b flush=%0b stall=%0b -> valid_e=%0b rd=%0d rs1=%0d rs2=%0d ill=%0b",
                 tag, ins, v, fl, es, valid_e, rd_e, rs1_e, rs2_e, illegal_e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_ex(tag, '0);
        chk({tag, ".stall"}, {30'd0, stall_f, stall_d}, 32'd0);
        chk_cnt(tag);
        $display("reset check %s", tag);
    endtask

    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst_n    = 1'b0;
        instr_d  = 32'd0;
        valid_d  = 1'b0;
        flush_i  = 1'b0;
        #3;
        chk_reset_state("reset0");
        // Valid load-shaped input during reset must not be captured
        instr_d = enc_i(OP_LOAD, 5'd5, 5'd1, 12'd0);
        valid_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset1");
        valid_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load then dependent add: one stall, a bubble, then the add
        step("lw_x5",   enc_i(OP_LOAD, 5'd5, 5'd1, 12'd0), 1, 0, 0, 1, 0);
        step("add_stl", enc_r(5'd6, 5'd5, 5'd2),           1, 0, 1, 0, 0);
        step("add_go",  enc_r(5'd6, 5'd5, 5'd2),           1, 0, 0, 1, 0);
        step("addi",    enc_i(OP_IALU, 5'd8, 5'd6, 12'd3), 1, 0, 0, 1, 0);

        // Store using loaded value as rs2
        step("lw_x7",   enc_i(OP_LOAD, 5'd7, 5'd3, 12'd0),  1, 0, 0, 1, 0);
        step("sw_stl",  enc_s(OP_STORE, 5'd2, 5'd7, 12'd4), 1, 0, 1, 0, 0);
        step("sw_go",   enc_s(OP_STORE, 5'd2, 5'd7, 12'd4), 1, 0, 0, 1, 0);

        // I-type whose immediate bits alias rs2 = rd of the load: rs2 unused, no stall
        step("lw_x12",  enc_i(OP_LOAD, 5'd12, 5'd1, 12'd0), 1, 0, 0, 1, 0);
        step("addi_12", enc_i(OP_IALU, 5'd13, 5'd1, 12'd12), 1, 0, 0, 1, 0);

        // Load to x0 then use x0: no hazard, rd=0 still registered
        step("lw_x0",   enc_i(OP_LOAD, 5'd0, 5'd1, 12'd0), 1, 0, 0, 1, 0);
        step("add_x0",  enc_r(5'd3, 5'd0, 5'd0),           1, 0, 0, 1, 0);

        // Hazard and flush on the same cycle: no stall, bubble, counter unchanged
        step("lw_x9",   enc_i(OP_LOAD, 5'd9, 5'd1, 12'd0), 1, 0, 0, 1, 0);
        step("flush",   enc_r(5'd10, 5'd9, 5'd9),          1, 1, 0, 0, 0);

        // Illegal opcode: one-cycle flag, then cleared by a bubble
        step("illegal", 32'h0000007F, 1, 0, 0, 0, 1);
        step("bubble",  enc_r(5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0);
        step("ill_fl",  32'h0000007F, 1, 1, 0, 0, 0);

        // Reset asserted mid-stall
        step("lw_x11",  enc_i(OP_LOAD, 5'd11, 5'd4, 12'd0), 1, 0, 0, 1, 0);
        instr_d = enc_s(OP_BRANCH, 5'd0, 5'd11, 12'd8);
        valid_d = 1'b1;
        #1;
        chk("beq_stall", {30'd0, stall_f, stall_d}, 32'd3);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk_reset_state("midreset");
        valid_d = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("postrst");
        step("beq",     enc_s(OP_BRANCH, 5'd1, 5'd2, 12'd8), 1, 0, 0, 1, 0);

        if (sb_q.size() != 0) begin
            chk("sb_empty", sb_q.size(), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_ctrl.md
ID_EX_CTRL -- requirements
Module: id_ex_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port instr_d, input, 32, instruction currently held in the ID stage.
REQ-004 SHALL have port valid_d, input, 1, instr_d is a real instruction (0 = bubble).
REQ-005 SHALL have port flush_i, input, 1, taken branch resolved in EX; kill the ID-stage instruction.
REQ-006 SHALL have ports valid_e, reg_write_e, mem_write_e, mem_read_e, alu_src_e, result_src_e, branch_e, all output, 1, registered ID/EX control bits.
REQ-007 SHALL have port imm_src_e, output, 2, registered immediate-format select (00 I, 01 S, 10 B; 11 never driven).
REQ-008 SHALL have ports rd_e, rs1_e, rs2_e, output, 5 each, registered register indices for writeback and forwarding.
REQ-009 SHALL have port illegal_e, output, 1, registered one-cycle flag for an unsupported opcode.
REQ-010 SHALL have ports stall_f and stall_d, output, 1 each, combinational hold requests for the PC and IF/ID registers.
REQ-011 SHALL have port stall_cnt, output, 32, load-use stall counter (present only per REQ-027).

Function
REQ-012 SHALL decode opcode instr_d[6:0] as follows.
- 0010011 I-ALU: imm 00, reg_write, alu_src.
- 0000011 load: imm 00, reg_write, mem_read, alu_src, result_src.
- 0100011 store: imm 01, mem_write, alu_src.
- 0110011 R-type: reg_write only, imm 00.
- 1100011 branch: imm 10, branch.
REQ-013 SHALL take rs1 = instr_d[19:15], rs2 = instr_d[24:20], rd = instr_d[11:7], registered unchanged into rs1_e/rs2_e/rd_e on every non-bubble update.
REQ-014 SHALL treat rs2 as used only for R-type, store and branch; rs1 as used by all five formats.
REQ-015 SHALL assert load-use hazard combinationally when all hold: valid_d, mem_read_e, valid_e, rd_e != 0, and rd_e matches a used source of instr_d.
REQ-016 SHALL drive stall_f = stall_d = hazard AND NOT flush_i.
REQ-017 SHALL insert a bubble into EX on the next edge when hazard, flush_i, !valid_d, or an illegal opcode applies: valid_e and all control bits 0, imm_src_e 00, indices 0.
REQ-018 SHALL, on a bubble, produce a single-cycle stall, since mem_read_e is 0 next cycle.
REQ-019 SHALL give flush_i priority over hazard: no stall, bubble inserted.
REQ-020 SHALL set illegal_e = 1 for one cycle after an edge where valid_d AND NOT flush_i AND opcode unsupported; otherwise illegal_e = 0.
REQ-021 SHALL otherwise register the decoded instruction with valid_e = 1, latency exactly one cycle.
REQ-022 SHALL keep x0 destination behaviour transparent: rd = 0 never triggers a hazard, but is still registered.

Reset
REQ-023 SHALL, while rst_n = 0, clear every registered output to 0 asynchronously, including stall_cnt.
REQ-024 SHALL force stall_f/stall_d to 0 during reset, because valid_e = 0.
REQ-025 SHALL, on reset asserted mid-stall, drop the stall immediately; the first post-reset instruction decodes normally.
REQ-026 SHALL release reset synchronously to clk; the first capturing edge is the one after rst_n rises.

Configuration
REQ-027 SHALL implement macro STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each edge where stall_d = 1, wrapping 0xFFFFFFFF to 0.
- Undefined: port stall_cnt and its register are absent; other behaviour is identical.

Verification
REQ-028 SHALL cover load then dependent add: lw x5,0(x1) then add x6,x5,x2 -> one cycle stall_f/stall_d = 1, then a bubble (valid_e = 0); the add appears in EX with rs1_e = 5 one cycle later.
REQ-029 SHALL cover a store using a loaded value as rs2: lw x7 then sw x7,4(x2) -> stall 1 cycle; the store enters EX with imm_src_e = 01, mem_write_e = 1.
REQ-030 SHALL cover load to x0 then use x0: lw x0 then add x3,x0,x0 -> no stall; the add follows directly.
REQ-031 SHALL cover hazard plus flush on the same cycle: stall_d = 0, bubble in EX, stall_cnt unchanged (STALL_CNT_EN defined).
REQ-032 SHALL cover illegal opcode 0x0000007F with valid_d = 1 -> illegal_e = 1 for one cycle, valid_e = 0.
REQ-033 SHALL cover rst_n pulled low during a stall -> all outputs 0 immediately, stall_cnt = 0; beq after release gives imm_src_e = 10, branch_e = 1.
